// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature period averager.
package temp_pkg;

    typedef logic [7:0] temp_code_t;

    typedef enum logic {
        SYNC  = 1'b0,
        ACCUM = 1'b1
    } avg_state_e;

    localparam temp_code_t SAT_CODE_DEF = 8'hFF;

endpackage

// File: rtl/temp_restart_det.sv
// Detects a restart of the upstream ramp counter and presents the period sample
// (the counter value just before the restart).
module temp_restart_det
    import temp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  temp_code_t count_in,
    output logic       restart,
    output temp_code_t sample
);

    temp_code_t prev_cnt_r;

    // Previous counter value, tracked every cycle regardless of enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cnt_r <= 8'd0;
        end else begin
            prev_cnt_r <= count_in;
        end
    end

    // A backwards step is a restart; a natural 255->0 wrap counts too
    assign restart = en && (count_in < prev_cnt_r);
    assign sample  = prev_cnt_r;

endmodule

// File: rtl/temp_period_avg.sv
// Averages 2^AVG_LOG2 ramp-period samples into an 8-bit temperature code on a
// valid/ready handshake. Optional hot alarm with hysteresis under TEMP_ALARM_EN.
module temp_period_avg
    import temp_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 2,
    parameter temp_code_t  SAT_CODE = SAT_CODE_DEF
`ifdef TEMP_ALARM_EN
    ,
    parameter temp_code_t  ALARM_HI = 8'd200,
    parameter temp_code_t  ALARM_LO = 8'd180
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] count_in,
    output logic [7:0] temp_code,
    output logic       temp_valid,
    input  logic       temp_ready,
    output logic       sat_flag,
    output logic       overrun,
    input  logic       clr_flags
`ifdef TEMP_ALARM_EN
    ,
    output logic       alarm
`endif
);

    localparam int unsigned ACC_W = 8 + AVG_LOG2;
    localparam int unsigned N_W   = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [N_W-1:0] N_LAST = N_W'((32'd1 << AVG_LOG2) - 32'd1);

    logic             restart_s;
    temp_code_t       sample_s;
    avg_state_e       state_r;
    avg_state_e       state_nxt_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [ACC_W-1:0] sum_s;
    logic [N_W-1:0]   n_r;
    logic [N_W-1:0]   n_nxt_s;
    logic             load_s;
    temp_code_t       result_s;
    logic             sat_set_s;
    logic             ovr_set_s;
    temp_code_t       temp_code_r;
    logic             temp_valid_r;
    logic             sat_flag_r;
    logic             overrun_r;

    temp_restart_det u_restart_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .count_in (count_in),
        .restart  (restart_s),
        .sample   (sample_s)
    );

    assign sum_s    = acc_r + ACC_W'(sample_s);
    assign result_s = temp_code_t'(sum_s >> AVG_LOG2);

    // Next-state and accumulator update; the last sample of a block loads the result
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        n_nxt_s     = n_r;
        load_s      = 1'b0;
        if (!en) begin
            state_nxt_s = SYNC;
            acc_nxt_s   = '0;
            n_nxt_s     = '0;
        end else begin
            case (state_r)
                SYNC: begin
                    // The first restart only aligns us; its partial period is dropped
                    if (restart_s) begin
                        state_nxt_s = ACCUM;
                        acc_nxt_s   = '0;
                        n_nxt_s     = '0;
                    end else begin
                        state_nxt_s = SYNC;
                    end
                end
                ACCUM: begin
                    if (restart_s) begin
                        if (n_r == N_LAST) begin
                            load_s    = 1'b1;
                            acc_nxt_s = '0;
                            n_nxt_s   = '0;
                        end else begin
                            acc_nxt_s = sum_s;
                            n_nxt_s   = n_r + N_W'(1);
                        end
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end
                default: begin
                    state_nxt_s = SYNC;
                    acc_nxt_s   = '0;
                    n_nxt_s     = '0;
                end
            endcase
        end
    end

    // FSM state and accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SYNC;
            acc_r   <= '0;
            n_r     <= '0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            n_r     <= n_nxt_s;
        end
    end

    // Result register and valid/ready handshake; a new result always loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temp_code_r  <= 8'd0;
            temp_valid_r <= 1'b0;
        end else if (load_s) begin
            temp_code_r  <= result_s;
            temp_valid_r <= 1'b1;
        end else if (temp_valid_r && temp_ready) begin
            temp_valid_r <= 1'b0;
        end else begin
            temp_valid_r <= temp_valid_r;
        end
    end

    assign sat_set_s = restart_s && (sample_s == SAT_CODE);
    assign ovr_set_s = load_s && temp_valid_r && !temp_ready;

    // Sticky status flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            if (sat_set_s) begin
                sat_flag_r <= 1'b1;
            end else if (clr_flags) begin
                sat_flag_r <= 1'b0;
            end else begin
                sat_flag_r <= sat_flag_r;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr_flags) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

`ifdef TEMP_ALARM_EN
    logic alarm_r;

    // Hot alarm with hysteresis: short period means hot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_r <= 1'b0;
        end else if (load_s && (result_s < ALARM_LO)) begin
            alarm_r <= 1'b1;
        end else if (load_s && (result_s > ALARM_HI)) begin
            alarm_r <= 1'b0;
        end else begin
            alarm_r <= alarm_r;
        end
    end

    assign alarm = alarm_r;
`endif

    assign temp_code  = temp_code_r;
    assign temp_valid = temp_valid_r;
    assign sat_flag   = sat_flag_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_temp_period_avg.sv
// Randomized self-checking bench for temp_period_avg against a queue-based
// reference model; alarm checks are compiled in with TEMP_ALARM_EN.
module tb_temp_period_avg;

    localparam int AVG_LOG2 = 2;
    localparam int N_AVG    = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] count_in;
    logic [7:0] temp_code;
    logic       temp_valid;
    logic       temp_ready;
    logic       sat_flag;
    logic       overrun;
    logic       clr_flags;
`ifdef TEMP_ALARM_EN
    logic       alarm;
`endif

    temp_period_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .count_in   (count_in),
        .temp_code  (temp_code),
        .temp_valid (temp_valid),
        .temp_ready (temp_ready),
        .sat_flag   (sat_flag),
        .overrun    (overrun),
        .clr_flags  (clr_flags)
`ifdef TEMP_ALARM_EN
        ,
        .alarm      (alarm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_prev;
    bit m_sync;
    int m_q[$];
    int m_code;
    bit m_valid;
    bit m_sat;
    bit m_ovr;
    bit m_alarm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = 0;
        m_sync  = 1'b1;
        m_q.delete();
        m_code  = 0;
        m_valid = 1'b0;
        m_sat   = 1'b0;
        m_ovr   = 1'b0;
        m_alarm = 1'b0;
    endtask

    // One clock edge of the reference behaviour, from the inputs held across it
    task automatic model_edge(input int cnt);
        bit restart;
        bit load;
        bit ovr_set;
        bit sat_set;
        int sample;
        int res;
        int sum;
        restart = en && (cnt < m_prev);
        sample  = m_prev;
        load    = 1'b0;
        res     = 0;
        if (!en) begin
            m_sync = 1'b1;
            m_q.delete();
        end else if (restart) begin
            if (m_sync) begin
                m_sync = 1'b0;
            end else begin
                m_q.push_back(sample);
                if (m_q.size() == N_AVG) begin
                    sum = 0;
                    foreach (m_q[i]) sum += m_q[i];
                    res  = sum / N_AVG;
                    load = 1'b1;
                    m_q.delete();
                end
            end
        end
        sat_set = restart && (sample == 255);
        ovr_set = load && m_valid && !temp_ready;
        if (load) begin
            m_code  = res;
            m_valid = 1'b1;
            if (res < 180) m_alarm = 1'b1;
            else if (res > 200) m_alarm = 1'b0;
        end else if (m_valid && temp_ready) begin
            m_valid = 1'b0;
        end
        if (sat_set) m_sat = 1'b1;
        else if (clr_flags) m_sat = 1'b0;
        if (ovr_set) m_ovr = 1'b1;
        else if (clr_flags) m_ovr = 1'b0;
        m_prev = cnt;
    endtask

    task automatic step(input int cnt);
        count_in = 8'(cnt);
        @(posedge clk);
        model_edge(cnt);
        #1;
        chk("code",  32'(temp_code),  32'(m_code));
        chk("valid", 32'(temp_valid), 32'(m_valid));
        chk("sat",   32'(sat_flag),   32'(m_sat));
        chk("ovr",   32'(overrun),    32'(m_ovr));
`ifdef TEMP_ALARM_EN
        chk("alarm", 32'(alarm),      32'(m_alarm));
`endif
    endtask

    task automatic ramp(input int peak);
        for (int v = 0; v <= peak; v++) step(v);
    endtask

    // Four equal periods, closed by the restart that captures the last one
    task automatic avg4(input int peak);
        for (int k = 0; k < 4; k++) ramp(peak);
        step(0);
    endtask

    task automatic resync();
        en = 1'b0;
        step(0);
        en = 1'b1;
        ramp(5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        count_in   = 8'd0;
        temp_ready = 1'b0;
        clr_flags  = 1'b0;
        model_reset();
        #12;
        chk("rst_code",  32'(temp_code),  32'd0);
        chk("rst_valid", 32'(temp_valid), 32'd0);
        chk("rst_sat",   32'(sat_flag),   32'd0);
        chk("rst_ovr",   32'(overrun),    32'd0);
        rst_n = 1'b1;

        // Partial ramp dropped, then 99/101/103/105 average to 102 for one cycle
        en = 1'b1;
        temp_ready = 1'b1;
        ramp(30);
        ramp(99);
        ramp(101);
        ramp(103);
        ramp(105);
        step(0);
        chk("t1_code",  32'(temp_code),  32'd102);
        chk("t1_valid", 32'(temp_valid), 32'd1);
        step(0);
        chk("t1_drop",  32'(temp_valid), 32'd0);

        // Two unaccepted results: overwrite and overrun, then clear flags
        temp_ready = 1'b0;
        avg4(50);
        chk("t2_first", 32'(temp_code), 32'd50);
        avg4(60);
        chk("t2_code",  32'(temp_code),  32'd60);
        chk("t2_valid", 32'(temp_valid), 32'd1);
        chk("t2_ovr",   32'(overrun),    32'd1);
        clr_flags = 1'b1;
        step(0);
        clr_flags = 1'b0;
        chk("t2_clr_ovr",   32'(overrun),    32'd0);
        chk("t2_clr_valid", 32'(temp_valid), 32'd1);
        temp_ready = 1'b1;
        step(0);
        chk("t2_accept", 32'(temp_valid), 32'd0);

        // Enable dropped mid-average discards the partial sum
        ramp(70);
        ramp(70);
        step(0);
        en = 1'b0;
        step(0);
        step(0);
        en = 1'b1;
        ramp(9);
        avg4(80);
        chk("t3_code",  32'(temp_code),  32'd80);
        chk("t3_valid", 32'(temp_valid), 32'd1);

        // Natural wrap: sample 255 is saturated and still averaged
        ramp(255);
        ramp(1);
        ramp(1);
        ramp(1);
        step(0);
        chk("t4_code", 32'(temp_code), 32'd64);
        chk("t4_sat",  32'(sat_flag),  32'd1);
        clr_flags = 1'b1;
        step(0);
        clr_flags = 1'b0;
        chk("t4_clr_sat", 32'(sat_flag), 32'd0);

        // Asynchronous reset while a result is pending mid-accumulation
        temp_ready = 1'b0;
        avg4(30);
        for (int v = 0; v <= 10; v++) step(v);
        chk("t5_pre_valid", 32'(temp_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_code",  32'(temp_code),  32'd0);
        chk("t5_rst_valid", 32'(temp_valid), 32'd0);
        chk("t5_rst_sat",   32'(sat_flag),   32'd0);
        chk("t5_rst_ovr",   32'(overrun),    32'd0);
        model_reset();
        rst_n = 1'b1;
        ramp(40);
        avg4(20);
        chk("t5_code",  32'(temp_code),  32'd20);
        chk("t5_valid", 32'(temp_valid), 32'd1);
        temp_ready = 1'b1;
        step(0);

`ifdef TEMP_ALARM_EN
        // Alarm hysteresis across the two thresholds
        resync();
        avg4(170);
        chk("al_170", 32'(alarm), 32'd1);
        avg4(190);
        chk("al_190", 32'(alarm), 32'd1);
        avg4(210);
        chk("al_210", 32'(alarm), 32'd0);
`endif

        // Randomized ramps with enable drops, back-pressure and flag clears
        for (int it = 0; it < 80; it++) begin
            int peak;
            peak       = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(1, 60));
            en         = ($urandom_range(0, 9) != 0);
            temp_ready = 1'(($urandom_range(0, 1)));
            clr_flags  = ($urandom_range(0, 7) == 0);
            ramp(peak);
            clr_flags  = 1'b0;
        end
        en = 1'b1;
        step(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/temp_period_avg.md
Name: temp_period_avg

Overview:
- Downstream consumer of the temperature-to-digital counter.
- The upstream 8-bit ramp counter restarts at 0 whenever the sensor comparator fires, so the count value just before each restart is the temperature-dependent period.
- This block detects each restart, captures the period sample, averages 2^AVG_LOG2 samples and presents an 8-bit temperature code on a valid/ready handshake, with range and overrun status.

Parameters:
- AVG_LOG2, 2, log2 of samples per average (legal range 0..4).
- SAT_CODE, 8'hFF, sample value treated as a saturated / stuck sensor.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  measurement enable
- count_in  input  8  upstream ramp counter value
- temp_code  output  8  averaged period code
- temp_valid  output  1  temp_code is pending
- temp_ready  input  1  consumer accepts temp_code
- sat_flag  output  1  sticky: a SAT_CODE sample was seen
- overrun  output  1  sticky: a pending result was overwritten
- clr_flags  input  1  synchronous clear of sat_flag and overrun

Behaviour:
- Reset (async assert, sync-release use): all outputs and internal registers are 0 and the FSM is in SYNC.
- Register prev_cnt <= count_in every cycle.
- Restart event: en=1 and count_in < prev_cnt. The sample is prev_cnt.
- FSM states:
  - SYNC: discard the partial first period. On a restart event, go to ACCUM with acc=0 and n=0; the event's own sample is dropped.
  - ACCUM: on each restart event, acc += sample and n += 1. When n reaches 2^AVG_LOG2-1 at an event, the final sum goes to the output register in the same edge.
  - Output register value: temp_code = (acc + sample) >> AVG_LOG2, truncating. Then acc=0, n=0, and the FSM stays in ACCUM.
  - en=0 in any state: next state is SYNC and acc/n are cleared. temp_valid and its pending temp_code are unaffected.
- Widths:
  - acc is 8+AVG_LOG2 bits, so there is no overflow.
  - n is AVG_LOG2 bits, or 1 bit when AVG_LOG2=0.
  - With AVG_LOG2=0 every restart event produces a result.
- Latency: the result is registered on the clock edge where the last restart is observed, so temp_valid is high the following cycle.
- Handshake:
  - temp_valid rises with a new result and holds, with temp_code stable, until a cycle with temp_valid & temp_ready. It then drops on the next edge.
  - New result while temp_valid=1 and not accepted that cycle: temp_code is overwritten, temp_valid stays 1, overrun <= 1.
  - New result in the same cycle as an acceptance: it loads, temp_valid stays 1, and there is no overrun.
- sat_flag is set by any captured sample == SAT_CODE, including samples dropped in SYNC.
  - A saturated sample is still accumulated.
- clr_flags clears both sticky flags. If a set and clr_flags coincide, set wins.
- A natural counter wrap 255->0 counts as a restart with sample 255 and sets sat_flag.

Optional Feature:
- TEMP_ALARM_EN. When defined, add:
  - Parameters ALARM_HI (default 8'd200) and ALARM_LO (default 8'd180).
  - Output port alarm, 1 bit.
- alarm is set when a loaded result is below ALARM_LO, since a short period means hot.
- alarm is cleared when a loaded result is above ALARM_HI.
- Between the two thresholds alarm holds its value; it resets to 0.
- When the macro is undefined, the port, parameters and logic are absent.

Decomposition:
- Package temp_pkg:
  - typedef of the 8-bit temperature code type.
  - FSM state enum {SYNC, ACCUM}.
  - Default constant for SAT_CODE.
- Optional sub-module temp_restart_det: holds prev_cnt and emits the restart pulse plus the sample. Everything else stays in the top block.

Test Plan:
- AVG_LOG2=2, en=1, with temp_ready=1 from the fourth restart onward:
  - Stimulus: one partial ramp, then ramps peaking at 99, 101, 103, 105.
  - Required: the first peak is discarded; after the fourth restart temp_valid=1 with temp_code=102 for exactly 1 cycle.
- Hold temp_ready=0 and complete two averages (peaks 4x50, then 4x60):
  - Required: temp_code=60, temp_valid=1, overrun=1.
  - Then pulse clr_flags: overrun=0 and temp_valid stays 1.
- Deassert en mid-average after 2 samples, then reassert:
  - Required: the next result uses only the post-SYNC samples; with peaks 4x80 after the discarded one, temp_code=80.
- Feed a free-running wrap 0..255->0:
  - Required: sat_flag=1, and the sample of 255 is included in the average.
- Assert rst_n low during ACCUM with temp_valid=1:
  - Required: all outputs are 0 immediately (asynchronously), and after release the first full ramp is discarded.
- TEMP_ALARM_EN defined:
  - Results 170 -> alarm=1.
  - Then 190 -> alarm stays 1.
  - Then 210 -> alarm=0.
